// File: rtl/uart_console_rx.sv
// ---------------------------------------------------------------------------
// uart_console_rx
//
// Console UART receiver: oversampling frame decoder feeding a
// first-word-fall-through receive FIFO, with sticky error flags.
//
// Build option:
//   UART_CONSOLE_RX_PARITY_EN  defined   -> 8E1 frames, par_err is live
//                              undefined -> 8N1 frames, par_err tied to 0
//
// Parameters:
//   DEPTH      receive FIFO depth in bytes (power of two, 4..256)
//
// Ports:
//   HCLK       system clock, rising edge
//   HRESETn    asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to HCLK
//   prescale   HCLK cycles per bit minus 1 (>= 3), captured at frame start
//   rd         pop the FIFO head (ignored while empty)
//   clr        clear the sticky error flags
//   rdata      FIFO head byte (0 while empty)
//   empty      FIFO holds no bytes
//   full       FIFO holds DEPTH bytes
//   overrun    sticky: a byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   par_err    sticky: parity mismatch (parity builds only)
// ---------------------------------------------------------------------------
module uart_console_rx #(
  parameter int DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        rx,
  input  logic [15:0] prescale,
  input  logic        rd,
  input  logic        clr,
  output logic [7:0]  rdata,
  output logic        empty,
  output logic        full,
  output logic        overrun,
  output logic        frame_err,
  output logic        par_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_CONSOLE_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  // Synchronizer plus one history flop for falling-edge detection.
  logic rx_meta, rx_sync, rx_prev;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] frame_ps_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;

  logic start_frame, shift_en, push, fe_set;
  logic sample, fall;

  assign sample = (cnt_q == 16'd0);
  assign fall   = rx_prev & ~rx_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state_q <= IDLE;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state_q <= state_d;
    end
  end

`ifdef UART_CONSOLE_RX_PARITY_EN
  logic pe_set;
`endif

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    push        = 1'b0;
    fe_set      = 1'b0;
`ifdef UART_CONSOLE_RX_PARITY_EN
    pe_set      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          start_frame = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        // Line back high at mid start bit: treat as a glitch.
        if (sample) state_d = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_CONSOLE_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_CONSOLE_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          pe_set  = (rx_sync != (^shift_q));
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rx_sync) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and data capture. The prescale is latched at frame start so
  // that a change mid-frame cannot disturb the bit timing.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q      <= 16'd0;
      frame_ps_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      if (start_frame) begin
        frame_ps_q <= prescale;
        cnt_q      <= prescale >> 1;  // first sample lands mid start bit
        bit_idx_q  <= 3'd0;
      end else if (state_q != IDLE && state_q != WAIT_IDLE) begin
        cnt_q <= sample ? frame_ps_q : cnt_q - 16'd1;
      end
      if (shift_en) begin
        shift_q   <= {rx_sync, shift_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO: extra pointer MSB distinguishes full from empty.
  // ---------------------------------------------------------------------
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = rd & ~empty;
  // A pop in the same cycle frees the slot, so a push while full still fits.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

  // NOTE: the storage array has no reset; its contents are never visible
  // until written, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Sticky flags: a set in the same cycle as clr wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (push & ~do_push) | (overrun & ~clr);
      frame_err <= fe_set | (frame_err & ~clr);
    end
  end

`ifdef UART_CONSOLE_RX_PARITY_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) par_err <= 1'b0;
    else          par_err <= pe_set | (par_err & ~clr);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_console_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_console_rx
//
// Directed bench for uart_console_rx (DEPTH=16, prescale=15). Expected
// received bytes go into a scoreboard queue; a monitor pops the FIFO
// whenever draining is enabled and compares against the queue head.
// Define UART_CONSOLE_RX_PARITY_EN for both files to run the parity case.
// ---------------------------------------------------------------------------
module tb_uart_console_rx;

  localparam int BIT = 16;  // prescale 15
`ifdef UART_CONSOLE_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] prescale = 16'd15;
  logic        rd = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  rdata;
  logic        empty, full, overrun, frame_err, par_err;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic        drain_en = 1'b0;
  logic [7:0]  exp_q[$];
`ifdef UART_CONSOLE_RX_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  uart_console_rx #(.DEPTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx), .prescale(prescale),
    .rd(rd), .clr(clr), .rdata(rdata), .empty(empty), .full(full),
    .overrun(overrun), .frame_err(frame_err), .par_err(par_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bit b of a frame: 0 = start, 1..8 = data LSB first, then parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int b,
                                     input logic stop_bit);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_CONSOLE_RX_PARITY_EN
    if (b == 9) return (^d) ^ par_flip;
`endif
    return stop_bit;
  endfunction

  // Sends the first nbits of a frame, then leaves the line idle high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int nbits);
    for (int b = 0; b < nbits; b++) begin
      rx = frame_bit(d, b, stop_bit);
      repeat (BIT) @(negedge HCLK);
    end
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge HCLK);
    clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    drain_en = 1'b1;
    while ((exp_q.size() != 0 || !empty) && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_empty"}, {31'd0, empty}, 1);
  endtask

  // Scoreboard monitor: sole driver of rd.
  always @(negedge HCLK) begin
    rd = 1'b0;
    if (drain_en && HRESETn && !empty) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'd0, rdata}, 32'hFFFF_FFFF);
      end else begin
        check("rx_byte", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
      end
      rd = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge HCLK);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_par_err", {31'd0, par_err}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);

    // 0x41: byte must appear exactly one cycle after the stop sample,
    // which falls 10 cycles into the stop bit (2 sync + 8 half-bit).
    for (int b = 0; b < FRAME_BITS - 1; b++) begin
      rx = frame_bit(8'h41, b, 1'b1);
      repeat (BIT) @(negedge HCLK);
    end
    rx = 1'b1;
    repeat (10) @(negedge HCLK);
    check("before_stop_sample_empty", {31'd0, empty}, 1);
    @(negedge HCLK);
    check("after_stop_sample_empty", {31'd0, empty}, 0);
    check("after_stop_sample_rdata", {24'd0, rdata}, 32'h41);
    repeat (5) @(negedge HCLK);
    exp_q.push_back(8'h41);
    wait_drain("frame41");

    // 5-cycle glitch: no push, no flags
    rx = 1'b0;
    repeat (5) @(negedge HCLK);
    rx = 1'b1;
    repeat (40) @(negedge HCLK);
    check("glitch_empty", {31'd0, empty}, 1);
    check("glitch_frame_err", {31'd0, frame_err}, 0);
    check("glitch_overrun", {31'd0, overrun}, 0);

    // 0x55 with low stop bit, then clr, then a good 0xA5
    send_frame(8'h55, 1'b0, FRAME_BITS);
    repeat (5) @(negedge HCLK);
    check("ferr_set", {31'd0, frame_err}, 1);
    check("ferr_empty", {31'd0, empty}, 1);
    pulse_clr();
    check("ferr_cleared", {31'd0, frame_err}, 0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, FRAME_BITS);
    wait_drain("frameA5");

    // 17 frames into a 16-deep FIFO without popping
    drain_en = 1'b0;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, FRAME_BITS);
    repeat (5) @(negedge HCLK);
    check("ovr_full", {31'd0, full}, 1);
    check("ovr_overrun", {31'd0, overrun}, 1);
    check("ovr_head", {24'd0, rdata}, 32'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    wait_drain("overrun_drain");
    check("ovr_full_after", {31'd0, full}, 0);
    pulse_clr();
    check("ovr_cleared", {31'd0, overrun}, 0);

    // Reset during the data bits of 0x3C, then a clean 0x7E
    send_frame(8'h3C, 1'b1, 4);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("midrst_empty", {31'd0, empty}, 1);
    check("midrst_rdata", {24'd0, rdata}, 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (20) @(negedge HCLK);
    check("postrst_empty", {31'd0, empty}, 1);
    check("postrst_frame_err", {31'd0, frame_err}, 0);
    check("postrst_overrun", {31'd0, overrun}, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, FRAME_BITS);
    wait_drain("frame7E");

`ifdef UART_CONSOLE_RX_PARITY_EN
    // 0x03 has even parity 0: bit 1 is a mismatch, byte still delivered
    drain_en = 1'b0;
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1, FRAME_BITS);
    repeat (3) @(negedge HCLK);
    check("par_bad_flag", {31'd0, par_err}, 1);
    check("par_bad_rdata", {24'd0, rdata}, 32'h03);
    exp_q.push_back(8'h03);
    wait_drain("par_bad");
    pulse_clr();
    par_flip = 1'b0;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, FRAME_BITS);
    wait_drain("par_good");
    check("par_good_flag", {31'd0, par_err}, 0);
`else
    check("par_err_tied", {31'd0, par_err}, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
